// File: rtl/conv1d_cfu_pkg.sv
// Shared definitions for the conv1d CFU command driver: CFU command codes,
// parameter register indices, FSM state encodings and the PARAM command table.
package conv1d_cfu_pkg;

  typedef enum logic [6:0] {
    CmdWrIn    = 7'd1,
    CmdWrFilt  = 7'd2,
    CmdInOff   = 7'd3,
    CmdDepth   = 7'd5,
    CmdStart   = 7'd6,
    CmdGetAcc  = 7'd7,
    CmdStartX  = 7'd8,
    CmdDone    = 7'd9,
    CmdBias    = 7'd12,
    CmdMult    = 7'd13,
    CmdShift   = 7'd14,
    CmdActMin  = 7'd15,
    CmdActMax  = 7'd16,
    CmdOutOff  = 7'd17,
    CmdNop     = 7'd127
  } cfu_cmd_e;

  localparam int unsigned NumParams = 9;

  localparam logic [3:0] CfgInOffset  = 4'd0;
  localparam logic [3:0] CfgDepth     = 4'd1;
  localparam logic [3:0] CfgStartX    = 4'd2;
  localparam logic [3:0] CfgBias      = 4'd3;
  localparam logic [3:0] CfgMult      = 4'd4;
  localparam logic [3:0] CfgShift     = 4'd5;
  localparam logic [3:0] CfgActMin    = 4'd6;
  localparam logic [3:0] CfgActMax    = 4'd7;
  localparam logic [3:0] CfgOutOffset = 4'd8;

  typedef logic [3:0] drv_state_e;

  localparam drv_state_e StIdle     = 4'd0;
  localparam drv_state_e StParam    = 4'd1;
  localparam drv_state_e StLdFilt   = 4'd2;
  localparam drv_state_e StLdIn     = 4'd3;
  localparam drv_state_e StStart    = 4'd4;
  localparam drv_state_e StPollIss  = 4'd5;
  localparam drv_state_e StPollWait = 4'd6;
  localparam drv_state_e StRdIss    = 4'd7;
  localparam drv_state_e StRdWait   = 4'd8;
  localparam drv_state_e StOut      = 4'd9;

  // Parameter register index -> CFU command that loads it.
  function automatic cfu_cmd_e param_cmd(input logic [3:0] idx);
    case (idx)
      CfgInOffset:  return CmdInOff;
      CfgDepth:     return CmdDepth;
      CfgStartX:    return CmdStartX;
      CfgBias:      return CmdBias;
      CfgMult:      return CmdMult;
      CfgShift:     return CmdShift;
      CfgActMin:    return CmdActMin;
      CfgActMax:    return CmdActMax;
      CfgOutOffset: return CmdOutOff;
      default:      return CmdNop;
    endcase
  endfunction

endpackage

// File: rtl/conv1d_cmd_driver_if.sv
// Bundle of the driver's config, job, word-stream, result-stream and CFU
// command signals. master = the driver, slave = its environment.
interface conv1d_cmd_driver_if #(
  parameter int unsigned CNT_W = 9
) ();
  logic             cfg_we;
  logic [3:0]       cfg_idx;
  logic [31:0]      cfg_wdata;
  logic             job_valid;
  logic             job_ready;
  logic [CNT_W-1:0] job_filt_words;
  logic [CNT_W-1:0] job_in_words;
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;
  logic             m_valid;
  logic             m_ready;
  logic [31:0]      m_data;
  logic             m_err;
  logic             cfu_en;
  logic [6:0]       cfu_cmd;
  logic [31:0]      cfu_inp0;
  logic [31:0]      cfu_inp1;
  logic [31:0]      cfu_ret;

  modport master (
    input  cfg_we, cfg_idx, cfg_wdata, job_valid, job_filt_words, job_in_words,
    input  s_valid, s_data, m_ready, cfu_ret,
    output job_ready, s_ready, m_valid, m_data, m_err, cfu_en, cfu_cmd, cfu_inp0, cfu_inp1
  );

  modport slave (
    output cfg_we, cfg_idx, cfg_wdata, job_valid, job_filt_words, job_in_words,
    output s_valid, s_data, m_ready, cfu_ret,
    input  job_ready, s_ready, m_valid, m_data, m_err, cfu_en, cfu_cmd, cfu_inp0, cfu_inp1
  );
endinterface

// File: rtl/conv1d_cmd_driver.sv
// Hardware initiator for the conv1d CFU: per job loads the parameter set,
// streams filter/input words, starts, polls done and returns the result.
// Optional poll timeout is enabled by defining CONV1D_DRV_TIMEOUT_EN.
module conv1d_cmd_driver
  import conv1d_cfu_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned CNT_W     = 9
`ifdef CONV1D_DRV_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
  input logic                 clk,
  input logic                 rst_n,
  conv1d_cmd_driver_if.master bus
);

  drv_state_e       state_q, state_d;
  logic [3:0]       pidx_q, pidx_d;
  logic [CNT_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] filt_q, filt_d;
  logic [CNT_W-1:0] in_q, in_d;
  logic [31:0]      cfg_q [NumParams];
  logic [31:0]      cfg_d [NumParams];
  logic [31:0]      snap_q [NumParams];
  logic [31:0]      snap_d [NumParams];
  logic             m_valid_q, m_valid_d;
  logic [31:0]      m_data_q, m_data_d;
  cfu_cmd_e         cmd;
  logic [31:0]      inp0, inp1;
  logic             word_last;

`ifdef CONV1D_DRV_TIMEOUT_EN
  logic [31:0]      tmo_q, tmo_d;
  logic             m_err_q, m_err_d;
`endif

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] n);
    return (n > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS) : n;
  endfunction

  // Parameter register file; writes accepted in every state.
  always_comb begin
    cfg_d = cfg_q;
    if (bus.cfg_we && (bus.cfg_idx < 4'(NumParams))) begin
      cfg_d[bus.cfg_idx] = bus.cfg_wdata;
    end
  end

  // Job FSM: next state plus the single CFU command issued this cycle.
  always_comb begin
    state_d   = state_q;
    pidx_d    = pidx_q;
    word_d    = word_q;
    filt_d    = filt_q;
    in_d      = in_q;
    snap_d    = snap_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    cmd       = CmdNop;
    inp0      = '0;
    inp1      = '0;
    word_last = (word_q + CNT_W'(1)) == ((state_q == StLdFilt) ? filt_q : in_q);

    case (state_q)
      StIdle: begin
        if (bus.job_valid) begin
          filt_d  = sat_cnt(bus.job_filt_words);
          in_d    = sat_cnt(bus.job_in_words);
          snap_d  = cfg_q;
          pidx_d  = '0;
          word_d  = '0;
          state_d = StParam;
        end
      end
      StParam: begin
        cmd    = param_cmd(pidx_q);
        inp1   = snap_q[pidx_q];
        pidx_d = pidx_q + 4'd1;
        if (pidx_q == 4'(NumParams - 1)) begin
          pidx_d  = '0;
          state_d = (filt_q != '0) ? StLdFilt : ((in_q != '0) ? StLdIn : StStart);
        end
      end
      StLdFilt, StLdIn: begin
        // A stall cycle leaves the address counter untouched and issues NOP.
        if (bus.s_valid) begin
          cmd    = (state_q == StLdFilt) ? CmdWrFilt : CmdWrIn;
          inp0   = {{(30 - CNT_W){1'b0}}, word_q, 2'b00};
          inp1   = bus.s_data;
          word_d = word_q + CNT_W'(1);
          if (word_last) begin
            word_d  = '0;
            state_d = (state_q == StLdFilt && in_q != '0) ? StLdIn : StStart;
          end
        end
      end
      StStart: begin
        cmd     = CmdStart;
        state_d = StPollIss;
      end
      StPollIss: begin
        cmd     = CmdDone;
        state_d = StPollWait;
      end
      StPollWait: begin
        state_d = bus.cfu_ret[0] ? StRdIss : StPollIss;
      end
      StRdIss: begin
        cmd     = CmdGetAcc;
        state_d = StRdWait;
      end
      StRdWait: begin
        m_data_d  = bus.cfu_ret;
        m_valid_d = 1'b1;
        state_d   = StOut;
      end
      StOut: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef CONV1D_DRV_TIMEOUT_EN
    tmo_d   = tmo_q;
    m_err_d = m_err_q;
    if (state_q == StIdle && bus.job_valid) m_err_d = 1'b0;
    if (state_q == StStart) tmo_d = '0;
    if (state_q == StPollIss || state_q == StPollWait) begin
      tmo_d = tmo_q + 32'd1;
      // A done seen in the final poll cycle still wins over the timeout.
      if ((tmo_q >= 32'(TIMEOUT_CYCLES - 1)) &&
          !(state_q == StPollWait && bus.cfu_ret[0])) begin
        m_data_d  = 32'h8000_0000;
        m_err_d   = 1'b1;
        m_valid_d = 1'b1;
        state_d   = StOut;
      end
    end
`endif
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pidx_q    <= '0;
      word_q    <= '0;
      filt_q    <= '0;
      in_q      <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      for (int i = 0; i < NumParams; i++) begin
        cfg_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pidx_q    <= pidx_d;
      word_q    <= word_d;
      filt_q    <= filt_d;
      in_q      <= in_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      cfg_q     <= cfg_d;
      snap_q    <= snap_d;
    end
  end

`ifdef CONV1D_DRV_TIMEOUT_EN
  // Poll budget counter and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q   <= '0;
      m_err_q <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      m_err_q <= m_err_d;
    end
  end
  assign bus.m_err = m_err_q;
`else
  assign bus.m_err = 1'b0;
`endif

  assign bus.job_ready = (state_q == StIdle);
  assign bus.s_ready   = (state_q == StLdFilt) || (state_q == StLdIn);
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.cfu_en    = 1'b1;
  assign bus.cfu_cmd   = cmd;
  assign bus.cfu_inp0  = inp0;
  assign bus.cfu_inp1  = inp1;

endmodule

// File: tb/tb_conv1d_cmd_driver.sv
// Directed bench for conv1d_cmd_driver with a small behavioural CFU model
// that logs every non-NOP command and answers DONE/GET_ACC polls.
module tb_conv1d_cmd_driver;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv1d_cmd_driver_if #(.CNT_W(9)) bus ();

  conv1d_cmd_driver #(
    .MAX_WORDS(256),
    .CNT_W(9)
`ifdef CONV1D_DRV_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          done_after = 1;
  logic [31:0] model_result = '0;
  int          polls = 0;
  int          src_mode = 0;
  int          src_idx  = 0;
  logic [31:0] src_base = '0;

  int          log_cmd [$];
  logic [31:0] log_a0 [$];
  logic [31:0] log_a1 [$];
  int          log_cyc [$];

  int          e_cmd [16] = '{3, 5, 8, 12, 13, 14, 15, 16, 17, 2, 2, 1, 1, 6, 9, 7};
  logic [31:0] e_a0 [16];
  logic [31:0] e_a1 [16];
  logic [31:0] prm [9];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int count_cmd(input int c);
    int n = 0;
    foreach (log_cmd[k]) if (log_cmd[k] == c) n++;
    return n;
  endfunction

  function automatic int first_idx(input int c);
    foreach (log_cmd[k]) if (log_cmd[k] == c) return k;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Word-stream source: advances on every accepted word.
  initial begin : stream_src
    logic fire;
    int   phase;
    phase = 0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    forever begin
      @(negedge clk);
      fire = bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      if (fire) src_idx++;
      phase = (phase == 2) ? 0 : phase + 1;
      bus.s_valid = (src_mode == 1) || (src_mode == 2 && phase == 0);
      bus.s_data  = src_base + 32'(src_idx);
    end
  end

  // CFU model: registered ret, valid the cycle after the issuing command.
  initial begin : cfu_model
    logic [6:0]  c;
    logic [31:0] a0, a1;
    bus.cfu_ret = '0;
    forever begin
      @(negedge clk);
      c  = bus.cfu_cmd;
      a0 = bus.cfu_inp0;
      a1 = bus.cfu_inp1;
      @(posedge clk);
      #1;
      if (c != 7'd127) begin
        log_cmd.push_back(int'(c));
        log_a0.push_back(a0);
        log_a1.push_back(a1);
        log_cyc.push_back(cyc);
      end
      case (c)
        7'd6: begin polls = 0; bus.cfu_ret = '0; end
        7'd9: begin polls++; bus.cfu_ret = (polls >= done_after) ? 32'd1 : 32'd0; end
        7'd7: bus.cfu_ret = model_result;
        default: bus.cfu_ret = '0;
      endcase
    end
  end

  task automatic cfg_write(input logic [3:0] idx, input logic [31:0] val);
    @(posedge clk); #1;
    bus.cfg_we = 1'b1; bus.cfg_idx = idx; bus.cfg_wdata = val;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic clear_log();
    log_cmd.delete(); log_a0.delete(); log_a1.delete(); log_cyc.delete();
  endtask

  task automatic start_job(input logic [8:0] f, input logic [8:0] i, output int acc);
    @(posedge clk); #1;
    bus.job_valid = 1'b1; bus.job_filt_words = f; bus.job_in_words = i;
    @(negedge clk);
    check_val("job_ready_idle", 32'(bus.job_ready), 32'd1);
    acc = cyc + 1;
    @(posedge clk); #1;
    bus.job_valid = 1'b0;
  endtask

  task automatic wait_mvalid(input int budget, output int seen);
    seen = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        seen = cyc;
        break;
      end
    end
    check_val("m_valid_arrives", 32'(seen >= 0), 32'd1);
  endtask

  task automatic take_result(input int hold, input logic [31:0] exp_data, input logic exp_err);
    check_val("m_data", bus.m_data, exp_data);
    check_val("m_err", 32'(bus.m_err), 32'(exp_err));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_val("hold_valid", 32'(bus.m_valid), 32'd1);
      check_val("hold_data", bus.m_data, exp_data);
    end
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    @(negedge clk);
    check_val("idle_after_out", 32'(bus.job_ready), 32'd1);
    check_val("m_valid_drop", 32'(bus.m_valid), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acc, seen, i6, i9, n9;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_wdata = '0;
    bus.job_valid = 1'b0; bus.job_filt_words = '0; bus.job_in_words = '0;
    bus.m_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check_val("rst_cmd", 32'(bus.cfu_cmd), 32'd127);
    check_val("rst_job_ready", 32'(bus.job_ready), 32'd1);
    check_val("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check_val("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check_val("rst_m_data", bus.m_data, 32'd0);
    check_val("rst_m_err", 32'(bus.m_err), 32'd0);
    check_val("rst_cfu_en", 32'(bus.cfu_en), 32'd1);
    check_val("rst_inp0", bus.cfu_inp0, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      prm[i] = 32'h100 + 32'(i * 17);
      cfg_write(4'(i), prm[i]);
    end

    // Job 1: filt=2, in=2, continuous stream, immediate done
    for (int k = 0; k < 16; k++) begin
      e_a0[k] = '0;
      e_a1[k] = '0;
    end
    for (int k = 0; k < 9; k++) e_a1[k] = prm[k];
    src_base = 32'hA000_0000;
    for (int k = 0; k < 4; k++) e_a1[9 + k] = src_base + 32'(k);
    e_a0[10] = 32'd4;
    e_a0[12] = 32'd4;
    done_after = 1; model_result = 32'd1234; src_idx = 0; src_mode = 1;
    clear_log();
    start_job(9'd2, 9'd2, acc);
    cfg_write(4'd0, 32'hDEAD_0000);  // lands mid-job, must not affect this job
    wait_mvalid(100, seen);
    take_result(0, 32'd1234, 1'b0);
    src_mode = 0;
    check_val("j1_log_size", 32'(log_cmd.size()), 32'd16);
    check_val("j1_first_cyc", 32'(log_cyc[0]), 32'(acc + 1));
    for (int k = 0; k < 15 && k < log_cmd.size(); k++) begin
      check_val($sformatf("j1_cmd%0d", k), 32'(log_cmd[k]), 32'(e_cmd[k]));
      check_val($sformatf("j1_a0_%0d", k), log_a0[k], e_a0[k]);
      check_val($sformatf("j1_a1_%0d", k), log_a1[k], e_a1[k]);
      check_val($sformatf("j1_cyc%0d", k), 32'(log_cyc[k]), 32'(log_cyc[0] + k));
    end

    // Job 2: new in_offset visible; filt=3 with s_valid 1-in-3
    src_base = 32'hB000_0000; src_idx = 0; src_mode = 2; model_result = 32'd5;
    repeat (3) @(posedge clk);
    clear_log();
    start_job(9'd3, 9'd0, acc);
    wait_mvalid(100, seen);
    take_result(0, 32'd5, 1'b0);
    src_mode = 0;
    check_val("j2_log_size", 32'(log_cmd.size()), 32'd15);
    check_val("j2_new_param", log_a1[0], 32'hDEAD_0000);
    for (int k = 0; k < 3 && 9 + k < log_cmd.size(); k++) begin
      check_val($sformatf("j2_cmd%0d", k), 32'(log_cmd[9 + k]), 32'd2);
      check_val($sformatf("j2_addr%0d", k), log_a0[9 + k], 32'(4 * k));
      check_val($sformatf("j2_data%0d", k), log_a1[9 + k], src_base + 32'(k));
      if (k > 0) check_val($sformatf("j2_gap%0d", k),
                           32'(log_cyc[9 + k] - log_cyc[8 + k]), 32'd3);
    end

    // Job 3: done after 5 polls, result -7, m_ready held low 3 cycles
    src_base = 32'hC000_0000; src_idx = 0; src_mode = 1;
    done_after = 5; model_result = 32'hFFFF_FFF9;
    clear_log();
    start_job(9'd1, 9'd1, acc);
    wait_mvalid(100, seen);
    take_result(3, 32'hFFFF_FFF9, 1'b0);
    src_mode = 0;
    n9 = count_cmd(9);
    check_val("j3_polls", 32'(n9), 32'd5);
    i6 = first_idx(6);
    i9 = first_idx(9);
    if (i6 >= 0 && i9 >= 0) begin
      check_val("j3_first_poll", 32'(log_cyc[i9] - log_cyc[i6]), 32'd1);
      for (int k = 1; k < n9; k++)
        check_val($sformatf("j3_poll_gap%0d", k),
                  32'(log_cyc[i9 + k] - log_cyc[i9 + k - 1]), 32'd2);
    end else begin
      check_val("j3_start_poll_found", 32'd0, 32'd1);
    end

    // Job 4: no words, immediate done -> 14 cycle latency
    done_after = 1; model_result = 32'd42;
    clear_log();
    start_job(9'd0, 9'd0, acc);
    wait_mvalid(50, seen);
    check_val("j4_latency", 32'(seen - acc), 32'd14);
    take_result(0, 32'd42, 1'b0);
    check_val("j4_no_wr_filt", 32'(count_cmd(2)), 32'd0);
    check_val("j4_no_wr_in", 32'(count_cmd(1)), 32'd0);
    check_val("j4_log_size", 32'(log_cmd.size()), 32'd12);

    // Job 5: oversized filter count saturates at 256 words
    src_base = 32'hD000_0000; src_idx = 0; src_mode = 1; model_result = 32'd77;
    clear_log();
    start_job(9'd511, 9'd0, acc);
    wait_mvalid(400, seen);
    take_result(0, 32'd77, 1'b0);
    src_mode = 0;
    check_val("j5_filt_words", 32'(count_cmd(2)), 32'd256);
    i6 = first_idx(6);
    if (i6 > 0) begin
      check_val("j5_last_addr", log_a0[i6 - 1], 32'd1020);
      check_val("j5_last_data", log_a1[i6 - 1], src_base + 32'd255);
    end else begin
      check_val("j5_start_found", 32'd0, 32'd1);
    end

    // Reset asserted while stalled in LD_IN
    src_idx = 0;
    start_job(9'd0, 9'd4, acc);
    seen = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        seen = k;
        break;
      end
    end
    check_val("mid_ld_in_reached", 32'(seen >= 0), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_val("mid_rst_cmd", 32'(bus.cfu_cmd), 32'd127);
    check_val("mid_rst_job_ready", 32'(bus.job_ready), 32'd1);
    check_val("mid_rst_s_ready", 32'(bus.s_ready), 32'd0);
    check_val("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

`ifdef CONV1D_DRV_TIMEOUT_EN
    // Done never set: timeout result within 18 cycles of START
    done_after = 1000000;
    clear_log();
    start_job(9'd0, 9'd0, acc);
    wait_mvalid(60, seen);
    i6 = first_idx(6);
    check_val("tmo_start_found", 32'(i6 >= 0), 32'd1);
    if (i6 >= 0) check_val("tmo_latency", 32'((seen - log_cyc[i6]) <= 18), 32'd1);
    take_result(0, 32'h8000_0000, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
